// File: rtl/generic_bus_sram_responder_if.sv
// Request/response bundle between a generic-bus initiator and the SRAM responder.
// The error line exists only when GEN_BUS_RESP_ERR_EN is defined.
interface generic_bus_sram_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ren;
  logic        wen;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        busy;
`ifdef GEN_BUS_RESP_ERR_EN
  logic        error;

  modport master (output addr, wdata, ren, wen, byte_en, input rdata, busy, error);
  modport slave  (input addr, wdata, ren, wen, byte_en, output rdata, busy, error);
`else
  modport master (output addr, wdata, ren, wen, byte_en, input rdata, busy);
  modport slave  (input addr, wdata, ren, wen, byte_en, output rdata, busy);
`endif
endinterface

// File: rtl/generic_bus_sram_responder.sv
// Word-addressed SRAM responder on the generic bus with fixed access latency and byte-lane writes.
// Define GEN_BUS_RESP_ERR_EN to add the error output and drop errored accesses.
module generic_bus_sram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                         CLK,
  input logic                         nRST,
  generic_bus_sram_responder_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = {1'b0, 32'(DEPTH_WORDS)} << 2;
  localparam logic [31:0] BAD_DATA = 32'hBAD1_BAD1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  byteEn_q;
  logic        isWrite_q;
  logic [31:0] rdata_q, rdata_d;
  logic        accept;
  logic [31:0] reqAddr;
  logic [3:0]  reqBe;
  logic        reqWrite;
  logic        readOk;
  logic        commitOk;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && (({1'b0, a} - {1'b0, BASE_ADDR}) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // In IDLE the live request is used so a zero-latency access can respond immediately.
  assign accept   = (state_q == IDLE) && (bus.ren || bus.wen);
  assign reqAddr  = (state_q == IDLE) ? bus.addr    : addr_q;
  assign reqBe    = (state_q == IDLE) ? bus.byte_en : byteEn_q;
  assign reqWrite = (state_q == IDLE) ? bus.wen     : isWrite_q;

`ifdef GEN_BUS_RESP_ERR_EN
  logic dual_q, err_q, err_d, reqDual, reqErr;

  function automatic logic misaligned(input logic [31:0] a, input logic [3:0] be);
    return ((be == 4'hF) && (a[1:0] != 2'b00)) ||
           (((be == 4'b0011) || (be == 4'b1100)) && a[0]);
  endfunction

  assign reqDual  = (state_q == IDLE) ? (bus.ren && bus.wen) : dual_q;
  assign reqErr   = !in_range(reqAddr) || misaligned(reqAddr, reqBe) || reqDual;
  assign readOk   = !reqErr;
  assign err_d    = (state_d == RESP) && reqErr;
  assign commitOk = (state_q == RESP) && isWrite_q && !err_q;
  assign bus.error = err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dual_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (accept) begin
        dual_q <= bus.ren && bus.wen;
      end
    end
  end
`else
  assign readOk   = in_range(reqAddr);
  assign commitOk = (state_q == RESP) && isWrite_q && in_range(addr_q);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        if (!bus.ren && !bus.wen) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Read data is registered on the edge that enters RESP, so it is valid for the whole busy-low cycle.
    if ((state_d == RESP) && !reqWrite) begin
      rdata_d = readOk ? mem[word_idx(reqAddr)] : BAD_DATA;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rdata_q   <= 32'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      byteEn_q  <= 4'd0;
      isWrite_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        addr_q    <= bus.addr;
        wdata_q   <= bus.wdata;
        byteEn_q  <= bus.byte_en;
        isWrite_q <= bus.wen;
      end
    end
  end

  // Array has no reset; a write lands on the edge leaving RESP.
  always_ff @(posedge CLK) begin
    if (commitOk) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn_q[i]) begin
          mem[word_idx(addr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.busy  = (state_q != RESP);
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_generic_bus_sram_responder.sv
// Self-checking bench: a LATENCY=2 / DEPTH=1024 responder at base 0 and a LATENCY=0 / DEPTH=16 one at 0x1000,
// both compared against a transaction-level memory model.
module tb_generic_bus_sram_responder;

  localparam int L2 = 2;
  localparam int L0 = 0;

  logic CLK = 1'b0;
  logic nRST;
  int   assertCount = 0;
  int   failCount   = 0;

  logic [31:0] modelMem [2][1024];
  logic [31:0] lastRd   [2];

  generic_bus_sram_responder_if bus2 ();
  generic_bus_sram_responder_if bus0 ();

  generic_bus_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(L2), .BASE_ADDR(32'h0000_0000)) dut2 (
    .CLK(CLK), .nRST(nRST), .bus(bus2));
  generic_bus_sram_responder #(.DEPTH_WORDS(16), .LATENCY(L0), .BASE_ADDR(32'h0000_1000)) dut0 (
    .CLK(CLK), .nRST(nRST), .bus(bus0));

  always #5 CLK = ~CLK;

  function automatic logic busyOf(input bit sel);
    return sel ? bus0.busy : bus2.busy;
  endfunction

  function automatic logic [31:0] rdataOf(input bit sel);
    return sel ? bus0.rdata : bus2.rdata;
  endfunction

  function automatic logic errorOf(input bit sel);
`ifdef GEN_BUS_RESP_ERR_EN
    return sel ? bus0.error : bus2.error;
`else
    return sel & 1'b0;
`endif
  endfunction

  function automatic int expLat(input bit sel);
    return (sel ? L0 : L2) + 1;
  endfunction

  task automatic drive(input bit sel, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (sel) begin
      bus0.ren = r; bus0.wen = w; bus0.addr = a; bus0.wdata = d; bus0.byte_en = be;
    end else begin
      bus2.ren = r; bus2.wen = w; bus2.addr = a; bus2.wdata = d; bus2.byte_en = be;
    end
  endtask

  // Transaction-level model: range check, optional error rules, lane merge, last-read tracking.
  task automatic modelXfer(input bit sel, input bit r, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be,
                           output logic [31:0] expRd, output logic expErr);
    longint unsigned base, depth, ua;
    bit inR;
    int idx;
    logic [31:0] word;
    base  = sel ? 64'h1000 : 64'h0;
    depth = sel ? 16 : 1024;
    ua    = a;
    inR   = (ua >= base) && (ua < base + 4 * depth);
    idx   = inR ? int'((ua - base) / 4) : 0;
    expErr = 1'b0;
`ifdef GEN_BUS_RESP_ERR_EN
    expErr = !inR || (r && w) || ((be == 4'hF) && (a % 4 != 0)) ||
             (((be == 4'h3) || (be == 4'hC)) && (a % 2 != 0));
`endif
    expRd = lastRd[sel];
    if (w) begin
      if (inR && !expErr) begin
        word = modelMem[sel][idx];
        for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = d[8*i +: 8];
        modelMem[sel][idx] = word;
      end
    end else if (r) begin
      expRd = (inR && !expErr) ? modelMem[sel][idx] : 32'hBAD1_BAD1;
      lastRd[sel] = expRd;
    end
  endtask

  // Drives one request, holds it until busy drops, then drops it and samples one cycle later.
  task automatic applyStimulus(input bit sel, input bit r, input bit w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] be,
                               output int lat, output logic [31:0] rd, output logic err,
                               output logic busyAfter, output logic [31:0] rdHeld);
    @(negedge CLK);
    drive(sel, r, w, a, d, be);
    lat = -1;
    rd  = 'x;
    err = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (busyOf(sel) === 1'b0) begin
        lat = k;
        rd  = rdataOf(sel);
        err = errorOf(sel);
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, a, d, be);
    @(negedge CLK);
    busyAfter = busyOf(sel);
    rdHeld    = rdataOf(sel);
  endtask

  task automatic test_reset;
    int lowCount;
    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    lastRd[0] = 32'd0;
    lastRd[1] = 32'd0;
    #1;
    assertCount++;
    if (bus2.busy !== 1'b1 || bus0.busy !== 1'b1) begin
      failCount++; $display("[TB] FAIL reset_busy: got %b/%b want 1/1", bus2.busy, bus0.busy);
    end
    assertCount++;
    if (bus2.rdata !== 32'd0 || bus0.rdata !== 32'd0) begin
      failCount++; $display("[TB] FAIL reset_rdata: got %h/%h want 0", bus2.rdata, bus0.rdata);
    end
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    lowCount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (bus2.busy !== 1'b1 || bus0.busy !== 1'b1 || bus2.rdata !== 32'd0 || bus0.rdata !== 32'd0)
        lowCount++;
    end
    assertCount++;
    if (lowCount !== 0) begin
      failCount++; $display("[TB] FAIL idle_quiet: got %0d bad cycles want 0", lowCount);
    end
  endtask

  task automatic test_write_read;
    int lat; logic [31:0] rd, held, expRd; logic err, bAfter, expErr;
    modelXfer(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, expRd, expErr);
    applyStimulus(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, err, bAfter, held);
    assertCount++;
    if (lat !== expLat(0)) begin failCount++; $display("[TB] FAIL wr_latency: got %0d want %0d", lat, expLat(0)); end
    assertCount++;
    if (bAfter !== 1'b1) begin failCount++; $display("[TB] FAIL wr_single_low: got busy %b want 1", bAfter); end
    modelXfer(0, 1, 0, 32'h10, 32'h0, 4'hF, expRd, expErr);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'hF, lat, rd, err, bAfter, held);
    assertCount++;
    if (lat !== expLat(0)) begin failCount++; $display("[TB] FAIL rd_latency: got %0d want %0d", lat, expLat(0)); end
    assertCount++;
    if (rd !== 32'hDEADBEEF || rd !== expRd) begin
      failCount++; $display("[TB] FAIL rd_data: got %h want %h", rd, 32'hDEADBEEF);
    end
    assertCount++;
    if (held !== expRd || bAfter !== 1'b1) begin
      failCount++; $display("[TB] FAIL rd_hold: got %h busy %b want %h busy 1", held, bAfter, expRd);
    end
  endtask

  task automatic test_partial_write;
    int lat; logic [31:0] rd, held, expRd; logic err, bAfter, expErr;
    modelXfer(0, 0, 1, 32'h20, 32'h11223344, 4'hF, expRd, expErr);
    applyStimulus(0, 0, 1, 32'h20, 32'h11223344, 4'hF, lat, rd, err, bAfter, held);
    modelXfer(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, expRd, expErr);
    applyStimulus(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, err, bAfter, held);
    assertCount++;
    if (lat !== expLat(0)) begin failCount++; $display("[TB] FAIL pw_latency: got %0d want %0d", lat, expLat(0)); end
    modelXfer(0, 1, 0, 32'h20, 32'h0, 4'hF, expRd, expErr);
    applyStimulus(0, 1, 0, 32'h20, 32'h0, 4'hF, lat, rd, err, bAfter, held);
    assertCount++;
    if (rd !== 32'h11BB33DD || rd !== expRd) begin
      failCount++; $display("[TB] FAIL pw_data: got %h want %h", rd, 32'h11BB33DD);
    end
    modelXfer(0, 0, 1, 32'h20, 32'h55555555, 4'h0, expRd, expErr);
    applyStimulus(0, 0, 1, 32'h20, 32'h55555555, 4'h0, lat, rd, err, bAfter, held);
    assertCount++;
    if (lat !== expLat(0)) begin failCount++; $display("[TB] FAIL be0_latency: got %0d want %0d", lat, expLat(0)); end
    modelXfer(0, 1, 0, 32'h20, 32'h0, 4'hF, expRd, expErr);
    applyStimulus(0, 1, 0, 32'h20, 32'h0, 4'hF, lat, rd, err, bAfter, held);
    assertCount++;
    if (rd !== 32'h11BB33DD) begin failCount++; $display("[TB] FAIL be0_unchanged: got %h want %h", rd, 32'h11BB33DD); end
  endtask

  task automatic test_out_of_range;
    int lat; logic [31:0] rd, held, expRd; logic err, bAfter, expErr;
    modelXfer(0, 1, 0, 32'h1000, 32'h0, 4'hF, expRd, expErr);
    applyStimulus(0, 1, 0, 32'h1000, 32'h0, 4'hF, lat, rd, err, bAfter, held);
    assertCount++;
    if (lat !== expLat(0) || bAfter !== 1'b1) begin
      failCount++; $display("[TB] FAIL oor_handshake: got lat %0d busy %b want %0d 1", lat, bAfter, expLat(0));
    end
    assertCount++;
    if (rd !== 32'hBAD1BAD1) begin failCount++; $display("[TB] FAIL oor_hi_data: got %h want %h", rd, 32'hBAD1BAD1); end
`ifdef GEN_BUS_RESP_ERR_EN
    assertCount++;
    if (err !== 1'b1) begin failCount++; $display("[TB] FAIL oor_error: got %b want 1", err); end
`endif
    modelXfer(1, 1, 0, 32'h0FFC, 32'h0, 4'hF, expRd, expErr);
    applyStimulus(1, 1, 0, 32'h0FFC, 32'h0, 4'hF, lat, rd, err, bAfter, held);
    assertCount++;
    if (lat !== expLat(1) || rd !== expRd) begin
      failCount++; $display("[TB] FAIL oor_lo: got lat %0d data %h want %0d %h", lat, rd, expLat(1), expRd);
    end
  endtask

  task automatic test_abort;
    int lat, lows; logic [31:0] rd, held, expRd; logic err, bAfter, expErr;
    modelXfer(0, 0, 1, 32'h30, 32'h0BADF00D, 4'hF, expRd, expErr);
    applyStimulus(0, 0, 1, 32'h30, 32'h0BADF00D, 4'hF, lat, rd, err, bAfter, held);
    @(negedge CLK);
    drive(0, 0, 1, 32'h30, 32'hFFFFFFFF, 4'hF);
    @(negedge CLK);
    drive(0, 0, 0, 32'h30, 32'hFFFFFFFF, 4'hF);
    lows = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (bus2.busy !== 1'b1) lows++;
    end
    assertCount++;
    if (lows !== 0) begin failCount++; $display("[TB] FAIL abort_busy: got %0d low cycles want 0", lows); end
    drive(0, 0, 1, 32'h30, 32'h12345678, 4'hF);
    @(negedge CLK);
    #1 nRST = 1'b0;
    #1;
    assertCount++;
    if (bus2.busy !== 1'b1 || bus2.rdata !== 32'd0) begin
      failCount++; $display("[TB] FAIL rst_mid: got busy %b rdata %h want 1 0", bus2.busy, bus2.rdata);
    end
    drive(0, 0, 0, 32'h30, 32'h12345678, 4'hF);
    lastRd[0] = 32'd0;
    lastRd[1] = 32'd0;
    #1 nRST = 1'b1;
    lows = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (bus2.busy !== 1'b1) lows++;
    end
    assertCount++;
    if (lows !== 0) begin failCount++; $display("[TB] FAIL rst_busy: got %0d low cycles want 0", lows); end
    modelXfer(0, 1, 0, 32'h30, 32'h0, 4'hF, expRd, expErr);
    applyStimulus(0, 1, 0, 32'h30, 32'h0, 4'hF, lat, rd, err, bAfter, held);
    assertCount++;
    if (rd !== 32'h0BADF00D || rd !== expRd) begin
      failCount++; $display("[TB] FAIL abort_data: got %h want %h", rd, 32'h0BADF00D);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] rd, held, expA, expB; logic err, bAfter, expErr;
    logic [3:0] pattern;
    logic [31:0] d1, d3;
    modelXfer(1, 0, 1, 32'h1000, 32'hCAFE0000, 4'hF, expA, expErr);
    applyStimulus(1, 0, 1, 32'h1000, 32'hCAFE0000, 4'hF, lat, rd, err, bAfter, held);
    assertCount++;
    if (lat !== expLat(1)) begin failCount++; $display("[TB] FAIL l0_wr_latency: got %0d want %0d", lat, expLat(1)); end
    modelXfer(1, 0, 1, 32'h1004, 32'hCAFE0004, 4'hF, expA, expErr);
    applyStimulus(1, 0, 1, 32'h1004, 32'hCAFE0004, 4'hF, lat, rd, err, bAfter, held);
    modelXfer(1, 1, 0, 32'h1000, 32'h0, 4'hF, expA, expErr);
    modelXfer(1, 1, 0, 32'h1004, 32'h0, 4'hF, expB, expErr);
    @(negedge CLK);
    drive(1, 1, 0, 32'h1000, 32'h0, 4'hF);
    @(negedge CLK); pattern[0] = bus0.busy; d1 = bus0.rdata;
    drive(1, 1, 0, 32'h1004, 32'h0, 4'hF);
    @(negedge CLK); pattern[1] = bus0.busy;
    @(negedge CLK); pattern[2] = bus0.busy; d3 = bus0.rdata;
    drive(1, 0, 0, 32'h1004, 32'h0, 4'hF);
    @(negedge CLK); pattern[3] = bus0.busy;
    assertCount++;
    if (pattern !== 4'b1010) begin failCount++; $display("[TB] FAIL b2b_busy: got %b want %b", pattern, 4'b1010); end
    assertCount++;
    if (d1 !== expA || d3 !== expB) begin
      failCount++; $display("[TB] FAIL b2b_data: got %h,%h want %h,%h", d1, d3, expA, expB);
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd, held, expRd, a, d; logic err, bAfter, expErr;
    bit r, w;
    logic [3:0] be;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      modelXfer(0, 0, 1, 32'(i * 4), d, 4'hF, expRd, expErr);
      applyStimulus(0, 0, 1, 32'(i * 4), d, 4'hF, lat, rd, err, bAfter, held);
    end
    for (int i = 0; i < 40; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 63)) :
                                         32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0, 1:    begin r = 1; w = 0; end
        2, 3:    begin r = 0; w = 1; end
        default: begin r = 1; w = 1; end
      endcase
      modelXfer(0, r, w, a, d, be, expRd, expErr);
      applyStimulus(0, r, w, a, d, be, lat, rd, err, bAfter, held);
      assertCount++;
      if (lat !== expLat(0) || rd !== expRd || bAfter !== 1'b1 || err !== expErr) begin
        failCount++;
        $display("[TB] FAIL rand_%0d: a=%h r%0d w%0d be=%h got lat %0d data %h err %b busy %b want %0d %h %b 1",
                 i, a, r, w, be, lat, rd, err, bAfter, expLat(0), expRd, expErr);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_partial_write;
    test_out_of_range;
    test_abort;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
